lut_neuron_cfg_writer: RTL and testbench
========================================

// Module: lut_neuron_cfg_writer
// PURPOSE
//  Runtime-programmable bank of FANIN-input, 1-bit-output LUT neurons plus the writer that loads their truth tables.
//  Truth tables arrive as a byte stream on a valid/ready config port. Each is assembled in a shadow register, then committed atomically.
//  Evaluation port: registered lookup of all neurons in parallel. Write-side counterpart of the fixed ROM neurons, for field retraining without resynthesis.
// PARAMETERS
//  FANIN        6   inputs per neuron; table depth TABLE_BITS = 2**FANIN (localparam)
//  NUM_NEURONS  8   neurons in the bank; IDX_W = max(1,$clog2(NUM_NEURONS)) (localparam)
//  CFG_W        8   config beat width; TABLE_BITS % CFG_W == 0; BEATS = TABLE_BITS/CFG_W (localparam)
// PORTS
//  clk          in   1                   single clock, rising edge
//  rst_n        in   1                   synchronous, active-low reset
//  cfg_valid    in   1                   config beat valid
//  cfg_ready    out  1                   config beat accepted when valid&ready
//  cfg_data     in   CFG_W               header beat: neuron index in [IDX_W-1:0]; payload beats: table bits, LSB-first
//  cfg_last     in   1                   marks final beat of a packet
//  cfg_err      out  1                   sticky protocol error; cleared by reset only
//  cfg_done     out  1                   1-cycle pulse when a table is committed
//  in_valid     in   1                   evaluation input valid
//  in_data      in   NUM_NEURONS*FANIN   neuron n fan-in = in_data[n*FANIN +: FANIN]
//  out_valid    out  1                   registered in_valid
//  out_data     out  NUM_NEURONS         out_data[n] = table[n][in code of neuron n]
// BEHAVIOUR
//  Reset: all tables and shadow = 0; FSM = HDR; cfg_ready=1, cfg_err=0, cfg_done=0, out_valid=0, out_data=0.
//  Lookup: bit index = unsigned fan-in code; code 6'b000001 selects table bit 1. Latency 1 cycle.
//  Lookup ignores in_valid for data: out_data is updated every cycle; out_valid qualifies it.
//  Packet format: 1 header beat followed by exactly BEATS payload beats. The last payload beat carries cfg_last.
//  Payload beat k fills shadow[k*CFG_W +: CFG_W].
//  FSM:
//   HDR: on beat, latch idx and clear beat count.
//     cfg_last=1 -> cfg_err=1, stay HDR.
//     idx >= NUM_NEURONS -> cfg_err=1, go DRAIN (cfg_last already checked).
//     otherwise -> LOAD.
//   LOAD: store beat, increment count.
//     cfg_last on beat k < BEATS-1 -> cfg_err=1, discard shadow, go HDR.
//     beat BEATS-1 with cfg_last=1 -> COMMIT.
//     beat BEATS-1 without cfg_last -> cfg_err=1, go DRAIN.
//   COMMIT: one cycle; cfg_ready=0; table[idx] <= shadow; cfg_done=1 next cycle; go HDR.
//   DRAIN: accept and discard beats until a beat with cfg_last, then go HDR. No table changes.
//  cfg_ready = 1 in HDR/LOAD/DRAIN, 0 in COMMIT.
//  cfg_valid low stalls any state indefinitely; no timeout.
//  Commit atomicity: a lookup in the commit cycle uses the old table; the new table is visible from the next cycle.
//  No partial table is ever visible.
//  Reset mid-packet: shadow and FSM discarded; committed tables also cleared to 0.
//  A second packet for the same idx overwrites fully; the last commit wins.
// CONFIGURATION
//  LUT_READBACK_EN defined: adds ports rb_idx (in, IDX_W) and rb_table (out, TABLE_BITS).
//   rb_table is registered table[rb_idx], 1-cycle latency, 0 when rb_idx >= NUM_NEURONS, reset 0.
//  LUT_READBACK_EN undefined: ports absent; no readback mux is built.
// STRUCTURE
//  Shared package lut_cfg_pkg:
//   cfg_state_e {HDR, LOAD, COMMIT, DRAIN}
//   function table_beats(FANIN, CFG_W)
//   default parameter constants
//  Sub-module lut_neuron_rt: one table register, write-enable, and registered lookup mux. Instantiated NUM_NEURONS times via generate.
//  Top level holds the FSM, shadow register, beat counter and error logic.
// TESTING
//  1. Reset, then in_data all 6'b111111 with in_valid=1 -> next cycle out_valid=1, out_data=8'h00.
//  2. Load idx 3 with table 64'h8000_0000_0000_0001 (8 beats, LSB first).
//     -> cfg_done pulse. Code 0 -> out_data[3]=1; code 63 -> 1; code 1 -> 0. Other neurons stay 0.
//  3. cfg_last asserted on payload beat 4 -> cfg_err=1, table unchanged.
//     A following well-formed packet still commits and pulses cfg_done.
//  4. Header idx=9 (NUM_NEURONS=8) + 8 payload beats + last -> cfg_err=1, all tables unchanged, FSM back in HDR.
//  5. Toggle cfg_valid randomly during a load, and hold a lookup on idx 2 across the commit cycle.
//     -> old value in the commit cycle, new value the next cycle.
//  6. Assert rst_n=0 after 5 payload beats -> all outputs back to reset values.
//     With LUT_READBACK_EN: rb_table for idx 2 equals the loaded table; 0 after reset.

Source files
------------

// File: rtl/lut_cfg_pkg.sv
// Shared types and defaults for the runtime-programmable LUT neuron bank.
// Optional feature macro: LUT_READBACK_EN (table readback port).
package lut_cfg_pkg;

   localparam int DEF_FANIN       = 6;
   localparam int DEF_NUM_NEURONS = 8;
   localparam int DEF_CFG_W       = 8;

   typedef enum logic [1:0] {
      HDR,
      LOAD,
      COMMIT,
      DRAIN
   } cfg_state_e;

   function automatic int table_beats(input int fanin, input int cfg_w);
      return (1 << fanin) / cfg_w;
   endfunction

endpackage

// File: rtl/lut_neuron_rt.sv
// One runtime-writable LUT neuron: table register plus registered lookup.
// Optional feature macro: LUT_READBACK_EN (exposes the table register).
module lut_neuron_rt
   import lut_cfg_pkg::*;
#(
   parameter int FANIN      = DEF_FANIN,
   parameter int TABLE_BITS = 1 << FANIN
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  we,
   input  logic [TABLE_BITS-1:0] wdata,
   input  logic [FANIN-1:0]      code,
`ifdef LUT_READBACK_EN
   output logic [TABLE_BITS-1:0] tbl_q,
`endif
   output logic                  lut_out
);

   logic [TABLE_BITS-1:0] tbl_r;

   // Lookup reads tbl_r before the write lands, so a commit is atomic.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tbl_r   <= '0;
         lut_out <= 1'b0;
      end else begin
         if (we) begin
            tbl_r <= wdata;
         end
         lut_out <= tbl_r[code];
      end
   end

`ifdef LUT_READBACK_EN
   assign tbl_q = tbl_r;
`endif

endmodule

// File: rtl/lut_neuron_cfg_writer.sv
// LUT neuron bank with byte-stream truth-table writer and shadow commit.
// Optional feature macro: LUT_READBACK_EN (adds rb_idx / rb_table).
module lut_neuron_cfg_writer
   import lut_cfg_pkg::*;
#(
   parameter int FANIN       = DEF_FANIN,
   parameter int NUM_NEURONS = DEF_NUM_NEURONS,
   parameter int CFG_W       = DEF_CFG_W,
   localparam int TABLE_BITS = 1 << FANIN,
   localparam int IDX_W      = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1,
   localparam int BEATS      = table_beats(FANIN, CFG_W),
   localparam int CNT_W      = (BEATS > 1) ? $clog2(BEATS) : 1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         cfg_valid,
   output logic                         cfg_ready,
   input  logic [CFG_W-1:0]             cfg_data,
   input  logic                         cfg_last,
   output logic                         cfg_err,
   output logic                         cfg_done,
   input  logic                         in_valid,
   input  logic [NUM_NEURONS*FANIN-1:0] in_data,
`ifdef LUT_READBACK_EN
   input  logic [IDX_W-1:0]             rb_idx,
   output logic [TABLE_BITS-1:0]        rb_table,
`endif
   output logic                         out_valid,
   output logic [NUM_NEURONS-1:0]       out_data
);

   cfg_state_e            state_q;
   cfg_state_e            state_d;
   logic [IDX_W-1:0]      idx_q;
   logic [IDX_W-1:0]      idx_d;
   logic [CNT_W-1:0]      cnt_q;
   logic [CNT_W-1:0]      cnt_d;
   logic [TABLE_BITS-1:0] shadow_q;
   logic [TABLE_BITS-1:0] shadow_d;
   logic                  err_q;
   logic                  err_d;
   logic                  done_q;
   logic                  beat;
   logic                  we;

   assign cfg_ready = (state_q != COMMIT);
   assign beat      = cfg_valid && cfg_ready;
   assign cfg_err   = err_q;
   assign cfg_done  = done_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= HDR;
         idx_q    <= '0;
         cnt_q    <= '0;
         shadow_q <= '0;
         err_q    <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         cnt_q    <= cnt_d;
         shadow_q <= shadow_d;
         err_q    <= err_d;
         done_q   <= (state_q == COMMIT);
      end
   end

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      cnt_d    = cnt_q;
      shadow_d = shadow_q;
      err_d    = err_q;
      we       = 1'b0;
      unique case (state_q)
         HDR: begin
            if (beat) begin
               idx_d = cfg_data[IDX_W-1:0];
               cnt_d = '0;
               // Range check uses the full beat, not just the idx field.
               if (cfg_last) begin
                  err_d = 1'b1;
               end else if (32'(cfg_data) >= NUM_NEURONS) begin
                  err_d   = 1'b1;
                  state_d = DRAIN;
               end else begin
                  state_d = LOAD;
               end
            end
         end
         LOAD: begin
            if (beat) begin
               shadow_d[int'(cnt_q)*CFG_W +: CFG_W] = cfg_data;
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CNT_W'(BEATS-1)) begin
                  if (cfg_last) begin
                     state_d = COMMIT;
                  end else begin
                     err_d   = 1'b1;
                     state_d = DRAIN;
                  end
               end else if (cfg_last) begin
                  err_d    = 1'b1;
                  shadow_d = '0;
                  state_d  = HDR;
               end
            end
         end
         COMMIT: begin
            we      = 1'b1;
            state_d = HDR;
         end
         DRAIN: begin
            if (beat && cfg_last) begin
               state_d = HDR;
            end
         end
         default: begin
            state_d = HDR;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
      end else begin
         out_valid <= in_valid;
      end
   end

`ifdef LUT_READBACK_EN
   logic [TABLE_BITS-1:0] tbl [NUM_NEURONS];
`endif

   for (genvar n = 0; n < NUM_NEURONS; n++) begin : g_neuron
      lut_neuron_rt #(
         .FANIN      (FANIN),
         .TABLE_BITS (TABLE_BITS)
      ) u_neuron (
         .clk     (clk),
         .rst_n   (rst_n),
         .we      (we && (idx_q == IDX_W'(n))),
         .wdata   (shadow_q),
         .code    (in_data[n*FANIN +: FANIN]),
`ifdef LUT_READBACK_EN
         .tbl_q   (tbl[n]),
`endif
         .lut_out (out_data[n])
      );
   end

`ifdef LUT_READBACK_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rb_table <= '0;
      end else if (32'(rb_idx) < NUM_NEURONS) begin
         rb_table <= tbl[rb_idx];
      end else begin
         rb_table <= '0;
      end
   end
`endif

endmodule

// File: tb/tb_lut_neuron_cfg_writer.sv
// Self-checking bench for lut_neuron_cfg_writer (optionally LUT_READBACK_EN).
module tb_lut_neuron_cfg_writer;

   localparam int FANIN = 6;
   localparam int NN    = 8;
   localparam int CFG_W = 8;

   logic        clk       = 1'b0;
   logic        rst_n     = 1'b0;
   logic        cfg_valid = 1'b0;
   logic [7:0]  cfg_data  = '0;
   logic        cfg_last  = 1'b0;
   logic        in_valid  = 1'b0;
   logic [47:0] in_data   = '0;
   logic        cfg_ready;
   logic        cfg_err;
   logic        cfg_done;
   logic        out_valid;
   logic [7:0]  out_data;
`ifdef LUT_READBACK_EN
   logic [2:0]  rb_idx = '0;
   logic [63:0] rb_table;
`endif

   always #5 clk = ~clk;

   lut_neuron_cfg_writer #(
      .FANIN       (FANIN),
      .NUM_NEURONS (NN),
      .CFG_W       (CFG_W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_data  (cfg_data),
      .cfg_last  (cfg_last),
      .cfg_err   (cfg_err),
      .cfg_done  (cfg_done),
      .in_valid  (in_valid),
      .in_data   (in_data),
`ifdef LUT_READBACK_EN
      .rb_idx    (rb_idx),
      .rb_table  (rb_table),
`endif
      .out_valid (out_valid),
      .out_data  (out_data)
   );

   int          n_chk    = 0;
   int          n_fail   = 0;
   int          done_cnt = 0;
   logic [63:0] mdl [NN];
   logic        pend_v   = 1'b0;
   int          pend_idx = 0;
   logic [63:0] pend_tbl = '0;
   logic [7:0]  sb_q [$];
   logic [7:0]  sb_exp;

   typedef struct {
      logic [47:0] din;
      logic [7:0]  exp;
   } vec_t;
   vec_t vecs [6];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [7:0] mdl_look(input logic [47:0] d);
      logic [7:0] r;
      for (int n = 0; n < NN; n++) r[n] = mdl[n][d[n*FANIN +: FANIN]];
      return r;
   endfunction

   always @(negedge clk) begin
      if (out_valid) begin
         n_chk++;
         if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL sb_empty: out_valid with nothing expected, out_data %h", out_data);
         end else begin
            sb_exp = sb_q.pop_front();
            if (out_data !== sb_exp) begin
               n_fail++;
               $display("FAIL sb_lookup: got %h expected %h", out_data, sb_exp);
            end
         end
      end
   end

   task automatic tick();
      if (in_valid) sb_q.push_back(mdl_look(in_data));
      @(posedge clk);
      #1;
      if (cfg_done) begin
         done_cnt++;
         if (pend_v) begin
            mdl[pend_idx] = pend_tbl;
            pend_v = 1'b0;
         end
      end
   endtask

   task automatic do_reset();
      in_valid  = 1'b0;
      cfg_valid = 1'b0;
      cfg_last  = 1'b0;
      rst_n     = 1'b0;
      tick();
      chk("rst_ready", 64'(cfg_ready), 64'd1);
      chk("rst_err", 64'(cfg_err), 64'd0);
      chk("rst_done", 64'(cfg_done), 64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_data", 64'(out_data), 64'd0);
`ifdef LUT_READBACK_EN
      chk("rst_rb_table", rb_table, 64'd0);
`endif
      tick();
      rst_n = 1'b1;
      for (int n = 0; n < NN; n++) mdl[n] = '0;
      pend_v = 1'b0;
   endtask

   task automatic send_beat(input logic [7:0] d, input logic l, input bit rnd);
      logic acc;
      int   guard;
      if (rnd) begin
         for (int g = 0; g < 3 && $urandom_range(0, 1) == 1; g++) begin
            cfg_valid = 1'b0;
            tick();
         end
      end
      cfg_valid = 1'b1;
      cfg_data  = d;
      cfg_last  = l;
      guard     = 0;
      acc       = 1'b0;
      while (!acc && guard < 20) begin
         acc = cfg_ready;
         tick();
         guard++;
      end
      if (!acc) chk("beat_timeout", 64'd0, 64'd1);
      cfg_valid = 1'b0;
      cfg_last  = 1'b0;
   endtask

   task automatic send_pkt(input logic [7:0] hdr, input logic [63:0] t, input bit rnd);
      send_beat(hdr, 1'b0, rnd);
      for (int k = 0; k < 8; k++) send_beat(t[k*8 +: 8], k == 7, rnd);
   endtask

   task automatic good_pkt(input int idx, input logic [63:0] t, input bit rnd);
      int d0;
      d0 = done_cnt;
      send_pkt(8'(idx), t, rnd);
      pend_v   = 1'b1;
      pend_idx = idx;
      pend_tbl = t;
      chk("commit_ready_low", 64'(cfg_ready), 64'd0);
      chk("done_not_early", 64'(cfg_done), 64'd0);
      tick();
      chk("done_pulse", 64'(done_cnt), 64'(d0 + 1));
      tick();
      chk("done_one_cycle", 64'(cfg_done), 64'd0);
   endtask

   task automatic rand_looks(input int cnt);
      for (int i = 0; i < cnt; i++) begin
         in_data  = 48'({$urandom(), $urandom()});
         in_valid = 1'b1;
         tick();
      end
      in_valid = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [63:0] t3;
      logic [63:0] t2;
      logic [63:0] t6;
      int          d0;

      t3 = 64'h8000_0000_0000_0001;
      vecs[0] = '{48'h0, 8'h08};
      vecs[1] = '{{8{6'h3f}}, 8'h08};
      vecs[2] = '{{8{6'd1}}, 8'h00};
      vecs[3] = '{{8{6'd62}}, 8'h00};
      vecs[4] = '{{{4{6'd0}}, 6'd63, {3{6'd0}}}, 8'h08};
      vecs[5] = '{{{4{6'd5}}, 6'd0, {3{6'd63}}}, 8'h08};

      do_reset();
      in_data  = {8{6'h3f}};
      in_valid = 1'b1;
      tick();
      chk("t1_out_valid", 64'(out_valid), 64'd1);
      chk("t1_out_data", 64'(out_data), 64'd0);
      in_valid = 1'b0;

      good_pkt(3, t3, 1'b0);
      for (int i = 0; i < 6; i++) begin
         in_data  = vecs[i].din;
         in_valid = 1'b1;
         tick();
         chk($sformatf("t2_vec%0d", i), 64'(out_data), 64'(vecs[i].exp));
      end
      in_valid = 1'b0;

      d0 = done_cnt;
      send_beat(8'd5, 1'b0, 1'b0);
      for (int k = 0; k < 5; k++) send_beat(8'($urandom()), k == 4, 1'b0);
      chk("t3_err", 64'(cfg_err), 64'd1);
      chk("t3_no_done", 64'(done_cnt), 64'(d0));
      rand_looks(4);
      good_pkt(5, {$urandom(), $urandom()}, 1'b1);
      rand_looks(6);

      do_reset();
      in_data  = '0;
      in_valid = 1'b1;
      tick();
      chk("rst_clears_tbl", 64'(out_data), 64'd0);
      in_valid = 1'b0;
      send_beat(8'd1, 1'b1, 1'b0);
      chk("hdr_last_err", 64'(cfg_err), 64'd1);
      good_pkt(1, {$urandom(), $urandom()}, 1'b0);
      rand_looks(4);

      do_reset();
      good_pkt(3, t3, 1'b0);
      d0 = done_cnt;
      send_pkt(8'd9, {$urandom(), $urandom()}, 1'b0);
      chk("t4_err", 64'(cfg_err), 64'd1);
      chk("t4_no_done", 64'(done_cnt), 64'(d0));
      chk("t4_ready_hdr", 64'(cfg_ready), 64'd1);
      rand_looks(5);
      t6 = {$urandom(), $urandom()};
      good_pkt(6, t6, 1'b1);
      rand_looks(5);

      d0 = done_cnt;
      send_beat(8'd1, 1'b0, 1'b0);
      for (int k = 0; k < 8; k++) send_beat(8'($urandom()), 1'b0, 1'b0);
      send_beat(8'hA5, 1'b1, 1'b0);
      chk("drain_no_done", 64'(done_cnt), 64'(d0));
      rand_looks(4);
      good_pkt(7, {$urandom(), $urandom()}, 1'b0);
      rand_looks(4);

      t2 = {$urandom(), $urandom()} | (64'd1 << 13);
      in_data  = {8{6'd13}};
      in_valid = 1'b1;
      send_pkt(8'd2, t2, 1'b1);
      pend_v   = 1'b1;
      pend_idx = 2;
      pend_tbl = t2;
      tick();
      chk("t5_done", 64'(cfg_done), 64'd1);
      chk("t5_commit_old", 64'(out_data[2]), 64'd0);
      tick();
      chk("t5_after_new", 64'(out_data[2]), 64'd1);
      in_valid = 1'b0;
`ifdef LUT_READBACK_EN
      rb_idx = 3'd2;
      tick();
      chk("rb_idx2", rb_table, t2);
      rb_idx = 3'd6;
      tick();
      chk("rb_idx6", rb_table, t6);
      rb_idx = 3'd2;
`endif

      send_beat(8'd4, 1'b0, 1'b0);
      for (int k = 0; k < 5; k++) send_beat(8'($urandom()), 1'b0, 1'b0);
      do_reset();
`ifdef LUT_READBACK_EN
      tick();
      chk("rb_after_rst", rb_table, 64'd0);
`endif
      in_data  = {8{6'd13}};
      in_valid = 1'b1;
      tick();
      chk("t6_tbl_cleared", 64'(out_data), 64'd0);
      in_valid = 1'b0;
      good_pkt(4, {$urandom(), $urandom()}, 1'b0);
      rand_looks(4);

      tick();
      tick();
      chk("sb_drained", 64'(sb_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
